// File: rtl/pc_pkg.sv
// pc_pkg: shared types, constants and coordinate check for placement_cost_eval
package pc_pkg;
  localparam int DW = 32;
  localparam logic signed [DW-1:0] POS_UNPLACED = -1;
  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_FE, S_WE, S_LA, S_WA, S_GA, S_WB, S_GB, S_ABS, S_ACC, S_RES
  } state_t;
  function automatic logic off_grid(input logic signed [DW-1:0] c, input int g);
    return (c == POS_UNPLACED) || (c < 0) || (c >= g);
  endfunction
endpackage

// File: rtl/pc_abs_acc.sv
// pc_abs_acc: per-edge Manhattan length and 1-hop term from two endpoint coordinates
//   xa, ya, xb, yb : endpoint coordinates (signed)
//   len            : |dx|+|dy|
//   hop            : ceil(|dx|/2) + ceil(|dy|/2) - 1
module pc_abs_acc
  import pc_pkg::*;
(
  input  logic signed [DW-1:0] xa,
  input  logic signed [DW-1:0] ya,
  input  logic signed [DW-1:0] xb,
  input  logic signed [DW-1:0] yb,
  output logic signed [DW-1:0] len,
  output logic signed [DW-1:0] hop
);
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0] adx, ady;
  always_comb begin
    dx  = xb - xa;
    dy  = yb - ya;
    adx = dx[DW-1] ? -dx : dx;
    ady = dy[DW-1] ? -dy : dy;
    len = adx + ady;
    hop = (adx >> 1) + DW'(adx[0]) + (ady >> 1) + DW'(ady[0]) - DW'(1);
  end
endmodule

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks edge ROMs and position RAMs, accumulating wirelength cost
//   clk, reset (async active-low), start/busy
//   e_re/e_addr -> ea_data/eb_data : edge ROM read (2-cycle latency)
//   p_re/p_addr -> px_data/py_data : position RAM read (2-cycle latency)
//   res_valid/res_ready, sum, sum_1hop, max_len, err_unplaced, err_overlap, err_edge
module placement_cost_eval
  import pc_pkg::*;
#(
  parameter int N_EDGE = 52,
  parameter int GRID_N = 7,
  parameter int EA_AW  = 8,
  parameter int POS_AW = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    e_re,
  output logic [EA_AW-1:0]        e_addr,
  input  logic signed [DW-1:0]    ea_data,
  input  logic signed [DW-1:0]    eb_data,
  output logic                    p_re,
  output logic [POS_AW-1:0]       p_addr,
  input  logic signed [DW-1:0]    px_data,
  input  logic signed [DW-1:0]    py_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [DW-1:0]    sum,
  output logic signed [DW-1:0]    sum_1hop,
  output logic signed [DW-1:0]    max_len,
  output logic                    err_unplaced,
  output logic                    err_overlap,
  output logic [EA_AW-1:0]        err_edge
);
  state_t state, nxt;
  logic [POS_AW-1:0] b_id;
  logic signed [DW-1:0] xa, ya, xb, yb, len, hop, len_r, hop_r;
  logic bad_r, last, ovl, unused_bits;
  assign unused_bits = ^{ea_data[DW-1:POS_AW], eb_data[DW-1:POS_AW]};
  assign last = e_addr == EA_AW'(N_EDGE - 1);
  assign ovl = len_r == '0;
  assign busy = state != S_IDLE;
  assign res_valid = state == S_RES;
  pc_abs_acc u_abs (.xa(xa), .ya(ya), .xb(xb), .yb(yb), .len(len), .hop(hop));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_CLR : S_IDLE;
      S_CLR:   nxt = S_FE;
      S_FE:    nxt = S_WE;
      S_WE:    nxt = S_LA;
      S_LA:    nxt = S_WA;
      S_WA:    nxt = S_GA;
      S_GA:    nxt = S_WB;
      S_WB:    nxt = S_GB;
      S_GB:    nxt = S_ABS;
      S_ABS:   nxt = S_ACC;
      S_ACC:   nxt = last ? S_RES : S_FE;
      S_RES:   nxt = res_ready ? S_IDLE : S_RES;
      default: nxt = S_IDLE;
    endcase
  end
  // Strobes are registered one cycle after FE/LA/GA; the memories respond one cycle
  // later, so data is consumed two states after the issuing state.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e_re <= 1'b0;
      e_addr <= '0;
      p_re <= 1'b0;
      p_addr <= '0;
      b_id <= '0;
      xa <= '0;
      ya <= '0;
      xb <= '0;
      yb <= '0;
      len_r <= '0;
      hop_r <= '0;
      bad_r <= 1'b0;
      sum <= '0;
      sum_1hop <= '0;
      max_len <= '0;
      err_unplaced <= 1'b0;
      err_overlap <= 1'b0;
      err_edge <= '0;
    end else begin
      e_re <= state == S_FE;
      p_re <= (state == S_LA) || (state == S_GA);
      case (state)
        S_CLR: begin
          e_addr <= '0;
          sum <= '0;
          sum_1hop <= '0;
          max_len <= '0;
          err_unplaced <= 1'b0;
          err_overlap <= 1'b0;
          err_edge <= '0;
        end
        S_LA: begin
          p_addr <= ea_data[POS_AW-1:0];
          b_id <= eb_data[POS_AW-1:0];
        end
        S_GA: begin
          xa <= px_data;
          ya <= py_data;
          p_addr <= b_id;
        end
        S_GB: begin
          xb <= px_data;
          yb <= py_data;
        end
        S_ABS: begin
          len_r <= len;
          hop_r <= hop;
          bad_r <= off_grid(xa, GRID_N) || off_grid(ya, GRID_N) ||
                   off_grid(xb, GRID_N) || off_grid(yb, GRID_N);
        end
        S_ACC: begin
          sum <= sum + len_r - DW'(1);
          sum_1hop <= sum_1hop + hop_r;
          max_len <= (len_r > max_len) ? len_r : max_len;
          if (bad_r) err_unplaced <= 1'b1;
          if (ovl) err_overlap <= 1'b1;
          // first failing edge wins: only record while no flag is set yet
          if ((bad_r || ovl) && !err_unplaced && !err_overlap) err_edge <= e_addr;
          if (!last) e_addr <= e_addr + EA_AW'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: scoreboard bench for placement_cost_eval
module tb_placement_cost_eval;
  localparam int NE = 52;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic busy, e_re, p_re, res_valid, err_unplaced, err_overlap;
  logic [7:0] e_addr, err_edge;
  logic [6:0] p_addr;
  logic signed [31:0] ea_data = '0, eb_data = '0, px_data = '0, py_data = '0;
  logic signed [31:0] sum, sum_1hop, max_len;
  logic signed [31:0] rom_a [256];
  logic signed [31:0] rom_b [256];
  logic signed [31:0] pos_x [128];
  logic signed [31:0] pos_y [128];
  typedef struct { int s; int h; int m; int ee; bit eu; bit eo; } exp_t;
  exp_t sb [$];
  int total = 0, bad = 0;

  placement_cost_eval dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .e_re(e_re), .e_addr(e_addr), .ea_data(ea_data), .eb_data(eb_data),
    .p_re(p_re), .p_addr(p_addr), .px_data(px_data), .py_data(py_data),
    .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .sum_1hop(sum_1hop),
    .max_len(max_len), .err_unplaced(err_unplaced), .err_overlap(err_overlap),
    .err_edge(err_edge)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (e_re) begin
      ea_data <= rom_a[e_addr];
      eb_data <= rom_b[e_addr];
    end
    if (p_re) begin
      px_data <= pos_x[p_addr];
      py_data <= pos_y[p_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model();
    exp_t r;
    r = '{s: 0, h: 0, m: 0, ee: 0, eu: 1'b0, eo: 1'b0};
    for (int i = 0; i < NE; i++) begin
      int xa, ya, xb, yb, adx, ady, len;
      bit off;
      xa = pos_x[rom_a[i]]; ya = pos_y[rom_a[i]];
      xb = pos_x[rom_b[i]]; yb = pos_y[rom_b[i]];
      adx = (xb > xa) ? xb - xa : xa - xb;
      ady = (yb > ya) ? yb - ya : ya - yb;
      len = adx + ady;
      off = xa < 0 || xa > 6 || ya < 0 || ya > 6 || xb < 0 || xb > 6 || yb < 0 || yb > 6;
      r.s += len - 1;
      r.h += (adx + 1) / 2 + (ady + 1) / 2 - 1;
      if (len > r.m) r.m = len;
      if ((off || len == 0) && !r.eu && !r.eo) r.ee = i;
      if (off) r.eu = 1'b1;
      if (len == 0) r.eo = 1'b1;
    end
    return r;
  endfunction

  task automatic setup_grid();
    for (int n = 0; n < 128; n++) begin
      pos_x[n] = n % 7;
      pos_y[n] = (n / 7) % 7;
    end
    for (int j = 0; j < 256; j++) begin
      rom_a[j] = j % 42;
      rom_b[j] = j % 42 + 7;
    end
  endtask

  task automatic setup_rand();
    for (int n = 0; n < 128; n++) begin
      pos_x[n] = $urandom_range(6);
      pos_y[n] = $urandom_range(6);
    end
    for (int j = 0; j < 256; j++) begin
      rom_a[j] = $urandom_range(127);
      rom_b[j] = $urandom_range(127);
    end
  endtask

  task automatic run(input int hold);
    exp_t e;
    int cyc;
    sb.push_back(model());
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 4;
    while (!res_valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, 1 + 9 * NE);
    e = sb.pop_front();
    repeat (hold) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", sum, e.s);
      chk("hold_max", max_len, e.m);
      tick();
    end
    chk("sum", sum, e.s);
    chk("sum_1hop", sum_1hop, e.h);
    chk("max_len", max_len, e.m);
    chk("err_unplaced", err_unplaced, e.eu);
    chk("err_overlap", err_overlap, e.eo);
    chk("err_edge", err_edge, e.ee);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    chk("valid_drop", res_valid, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_sum_held", sum, e.s);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_e_re", e_re, 0);
    chk("rst_sum", sum, 0);
    chk("rst_err", {err_unplaced, err_overlap}, 0);
    reset = 1'b1;
    tick();
    setup_rand();
    for (int j = 0; j < NE; j++) begin
      rom_a[j] = 100;
      rom_b[j] = 101;
    end
    pos_x[100] = 0; pos_y[100] = 0; pos_x[101] = 3; pos_y[101] = 4;
    run(0);
    chk("t1_sum_const", sum, 6 * NE);
    chk("t1_hop_const", sum_1hop, 3 * NE);
    chk("t1_max_const", max_len, 7);
    setup_grid();
    run(0);
    chk("t2_sum_const", sum, 0);
    chk("t2_hop_const", sum_1hop, 0);
    chk("t2_max_const", max_len, 1);
    setup_grid();
    pos_x[rom_b[2]] = -1;
    run(0);
    chk("t3_unplaced", err_unplaced, 1);
    chk("t3_edge", err_edge, 2);
    setup_rand();
    rom_a[0] = 110; rom_b[0] = 111;
    pos_x[110] = 5; pos_y[110] = 5; pos_x[111] = 5; pos_y[111] = 5;
    run(0);
    chk("t4_overlap", err_overlap, 1);
    chk("t4_edge", err_edge, 0);
    setup_rand();
    run(20);
    run(0);
    setup_rand();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1 + 9 * 10) tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_hop", sum_1hop, 0);
    chk("abort_max", max_len, 0);
    chk("abort_strobes", {e_re, p_re, res_valid}, 0);
    #1;
    reset = 1'b1;
    tick();
    run(0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
